// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM type, round constants and GF(2^8) S-box/round helpers for the AES-128 round controller
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_ctrl_state_t;
  localparam int AES_ROUNDS = 10;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] e, r;
    e = 8'hfe;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = e[i] ? gmul(r, x) : r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational AES-128 next round key from the current key and RCON byte
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon,
  output logic [127:0] nkey
);
  logic [31:0] t, n0, n1, n2, n3;
  assign t  = {sbox(rkey[23:16]) ^ rcon, sbox(rkey[15:8]), sbox(rkey[7:0]), sbox(rkey[31:24])};
  assign n0 = rkey[127:96] ^ t;
  assign n1 = rkey[95:64] ^ n0;
  assign n2 = rkey[63:32] ^ n1;
  assign n3 = rkey[31:0] ^ n2;
  assign nkey = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_datapath.sv
// round/final_round: combinational AES full round and final round (no MixColumns)
module round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);
  assign state_out = mix_columns(sub_shift(state_in)) ^ round_key;
endmodule

module final_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);
  assign state_out = sub_shift(state_in) ^ round_key;
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption controller; AES_ROUND_CTRL_ABORT_EN adds an abort input
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  aes_ctrl_state_t fsm, nxt;
  logic [127:0] state_q, rkey_q, nkey, rnd_out, fin_out;
  logic [3:0] rnd_q;
  logic ab, clr;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign ab = abort && fsm != IDLE;
`else
  assign ab = 1'b0;
`endif
  aes_key_step u_key (.rkey(rkey_q), .rcon(RCON[rnd_q]), .nkey(nkey));
  round u_round (.state_in(state_q), .round_key(nkey), .state_out(rnd_out));
  final_round u_final (.state_in(state_q), .round_key(nkey), .state_out(fin_out));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= IDLE;
    else fsm <= nxt;
  always_comb begin
    nxt = ab ? IDLE :
          fsm == IDLE  ? (in_valid ? ROUND : IDLE) :
          fsm == ROUND ? (rnd_q == 4'(AES_ROUNDS - 1) ? FINAL : ROUND) :
          fsm == FINAL ? DONE :
          (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready   = fsm == IDLE;
    busy       = fsm != IDLE;
    out_valid  = fsm == DONE;
    ciphertext = fsm == DONE ? state_q : '0;
  end
  assign clr = fsm != IDLE && nxt == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
    end else if (clr) begin
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
    end else if (fsm == IDLE && in_valid) begin
      state_q <= plaintext ^ key;
      rkey_q  <= key;
      rnd_q   <= 4'd1;
    end else if (fsm == ROUND) begin
      state_q <= rnd_out;
      rkey_q  <= nkey;
      rnd_q   <= rnd_q + 4'd1;
    end else if (fsm == FINAL)
      state_q <= fin_out;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl with FIPS-197 vectors
module tb_aes_round_ctrl;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] plaintext = '0, key = '0, ciphertext;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic [127:0] sb [$];
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort = 0;
`endif
  aes_round_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .plaintext(plaintext),
    .key(key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ciphertext(ciphertext),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 128'(in_ready), 128'd1);
    plaintext = pt;
    key = k;
    in_valid = 1;
    sb.push_back(exp);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 0;
    chk("busy_after_accept", 128'(busy), 128'd1);
  endtask
  task automatic finish_block(input int hold);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 128'(out_valid), 128'd1);
    chk("latency", 128'(cyc - acc_cyc), 128'd10);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ct", ciphertext, sb[0]);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1;
    chk("ciphertext", ciphertext, sb.pop_front());
    @(negedge clk);
    out_ready = 0;
    chk("retire_out_valid", 128'(out_valid), 128'd0);
    chk("retire_in_ready", 128'(in_ready), 128'd1);
    chk("retire_ct_zero", ciphertext, 128'd0);
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_ct"}, ciphertext, 128'd0);
  endtask
  initial begin
    #1 check_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start(PB, KB, CB);
    finish_block(0);
    start(PC, KC, CC);
    finish_block(0);
    start(PB, KB, CB);
    finish_block(20);
    start(PB, KB, CB);
    for (int i = 0; i < 4; i++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      in_valid = ~in_valid;
      out_ready = 1;
      @(negedge clk);
      chk("iso_in_ready", 128'(in_ready), 128'd0);
      chk("iso_out_valid", 128'(out_valid), 128'd0);
    end
    in_valid = 0;
    out_ready = 0;
    finish_block(0);
    @(negedge clk);
    check_idle("iso_no_second");
    chk("sb_empty", 128'(sb.size()), 128'd0);
    start(PB, KB, CB);
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1 check_idle("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start(PC, KC, CC);
    finish_block(0);
`ifdef AES_ROUND_CTRL_ABORT_EN
    start(PB, KB, CB);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("pre_abort_out_valid", 128'(out_valid), 128'd0);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_idle("abort");
    sb.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_pulse", 128'(out_valid), 128'd0);
    start(PC, KC, CC);
    finish_block(0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
